// File: rtl/mod_pkg.sv
// Shared definitions for the MOD/DIV datapath.
//   DEFAULT_WIDTH : default operand/result width
//   CMD_LOAD      : {we,s} encoding that loads a new operand pair
//   CMD_STEP      : {we,s} encoding that performs one subtract step
package mod_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] CMD_LOAD = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

endpackage

// File: rtl/mod_sub_cmp.sv
// Combinational WIDTH+1 bit subtractor/comparator for the MOD/DIV datapath.
// Ports:
//   r      in   WIDTH  current remainder
//   b      in   WIDTH  divisor
//   diff   out  WIDTH  r - b (low WIDTH bits)
//   borrow out  1      r < b (unsigned)
//   b_zero out  1      divisor is zero
module mod_sub_cmp
    import mod_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             b_zero
);

    logic [WIDTH:0] diff_full;

    // The extra top bit is the borrow out, which doubles as the r < b compare.
    assign diff_full = {1'b0, r} - {1'b0, b};
    assign diff      = diff_full[WIDTH-1:0];
    assign borrow    = diff_full[WIDTH];
    assign b_zero    = (b == '0);

endmodule

// File: rtl/mod_datapath.sv
// Datapath for the multi-cycle MOD/DIV unit. Computes A mod B and A / B by
// repeated subtraction under control of the mod control unit.
// Ports:
//   CLK       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high
//   a_in      in   WIDTH  dividend
//   b_in      in   WIDTH  divisor
//   we        in   1      register write enable
//   s         in   1      0: load operands, 1: subtract step
//   result    in   1      control unit in terminal state
//   is_less   out  1      R < B or B == 0
//   rem_out   out  WIDTH  registered remainder
//   quo_out   out  WIDTH  registered quotient
//   valid     out  1      one-cycle pulse when rem_out/quo_out update
//   div_zero  out  1      current operation had B == 0
//   busy      out  1      operation loaded and result not yet captured
module mod_datapath
    import mod_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             we,
    input  logic             s,
    input  logic             result,
    output logic             is_less,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out,
    output logic             valid,
    output logic             div_zero,
    output logic             busy
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] q_q;
    logic             result_d;

    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             b_zero;
    logic             result_rise;
    logic [WIDTH-1:0] q_inc;

    mod_sub_cmp #(
        .WIDTH (WIDTH)
    ) u_sub_cmp (
        .r      (r_q),
        .b      (b_q),
        .diff   (diff),
        .borrow (borrow),
        .b_zero (b_zero)
    );

    // B == 0 forces termination so the control unit can never loop forever.
    assign is_less     = borrow | b_zero;
    assign result_rise = result & ~result_d;
    // Quotient saturates rather than wrapping.
    assign q_inc       = (q_q == '1) ? q_q : q_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            rem_out  <= '0;
            quo_out  <= '0;
            valid    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            result_d <= 1'b0;
        end else begin
            result_d <= result;
            valid    <= result_rise;

            // Capture sees pre-LOAD R/Q; a concurrent LOAD then re-asserts busy below.
            if (result_rise) begin
                rem_out <= r_q;
                quo_out <= q_q;
                busy    <= 1'b0;
            end

            case ({we, s})
                CMD_LOAD: begin
                    r_q      <= a_in;
                    b_q      <= b_in;
                    q_q      <= '0;
                    busy     <= 1'b1;
                    div_zero <= (b_in == '0);
                end
                CMD_STEP: begin
                    // A step while R < B (or B == 0) is illegal and ignored.
                    if (!is_less) begin
                        r_q <= diff;
                        q_q <= q_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_datapath.sv
// Self-checking directed bench for mod_datapath (WIDTH = 32).
module tb_mod_datapath;

    logic        CLK;
    logic        reset;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        we;
    logic        s;
    logic        result;
    logic        is_less;
    logic [31:0] rem_out;
    logic [31:0] quo_out;
    logic        valid;
    logic        div_zero;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mod_datapath #(
        .WIDTH (32)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .a_in     (a_in),
        .b_in     (b_in),
        .we       (we),
        .s        (s),
        .result   (result),
        .is_less  (is_less),
        .rem_out  (rem_out),
        .quo_out  (quo_out),
        .valid    (valid),
        .div_zero (div_zero),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] b);
        we = 1'b1; s = 1'b0; a_in = a; b_in = b;
        tick();
        we = 1'b0;
    endtask

    task automatic do_steps(input int n);
        for (int i = 0; i < n; i++) begin
            we = 1'b1; s = 1'b1;
            tick();
        end
        we = 1'b0; s = 1'b0;
    endtask

    // Raise result for one cycle, then drop it; outputs checked on the capture cycle.
    task automatic do_capture(input string tag, input logic [31:0] rem_exp,
                              input logic [31:0] quo_exp);
        result = 1'b1;
        tick();
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_rem"}, rem_out, rem_exp);
        check({tag, "_quo"}, quo_out, quo_exp);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        result = 1'b0;
        tick();
        check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int pulses;
        int steps;

        reset = 1'b1; we = 1'b0; s = 1'b0; result = 1'b0; a_in = '0; b_in = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_rem", rem_out, 32'd0);
        check("rst_quo", quo_out, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_less", 32'(is_less), 32'd1);

        // 1: 17 / 5
        do_load(32'd17, 32'd5);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_less_load", 32'(is_less), 32'd0);
        do_steps(2);
        check("t1_less_2", 32'(is_less), 32'd0);
        do_steps(1);
        check("t1_less_3", 32'(is_less), 32'd1);
        do_capture("t1", 32'd2, 32'd3);

        // 2: 4 / 9, no steps
        do_load(32'd4, 32'd9);
        check("t2_less", 32'(is_less), 32'd1);
        do_capture("t2", 32'd4, 32'd0);

        // 3: divide by zero
        do_load(32'd123, 32'd0);
        check("t3_less", 32'(is_less), 32'd1);
        check("t3_dz_load", 32'(div_zero), 32'd1);
        do_steps(1);
        do_capture("t3", 32'd123, 32'd0);
        check("t3_dz", 32'(div_zero), 32'd1);

        // 4: 20 / 4, five steps plus one illegal step; capture concurrent with LOAD 9/2
        do_load(32'd20, 32'd4);
        check("t4_dz_clear", 32'(div_zero), 32'd0);
        do_steps(5);
        check("t4_less", 32'(is_less), 32'd1);
        do_steps(1);
        check("t4_less_extra", 32'(is_less), 32'd1);
        result = 1'b1; we = 1'b1; s = 1'b0; a_in = 32'd9; b_in = 32'd2;
        tick();
        we = 1'b0; result = 1'b0;
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_rem", rem_out, 32'd0);
        check("t4_quo", quo_out, 32'd5);
        check("t4_busy_reload", 32'(busy), 32'd1);
        check("t4_less_reload", 32'(is_less), 32'd0);
        tick();
        check("t4_valid_drop", 32'(valid), 32'd0);

        // 5: finish 9 / 2 with result held high for 10 cycles
        do_steps(4);
        check("t5_less", 32'(is_less), 32'd1);
        pulses = 0;
        result = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) pulses++;
        end
        result = 1'b0;
        tick();
        if (valid) pulses++;
        check("t5_pulses", 32'(pulses), 32'd1);
        check("t5_rem", rem_out, 32'd1);
        check("t5_quo", quo_out, 32'd4);
        check("t5_busy", 32'(busy), 32'd0);

        // 6: reset mid-operation of 50 / 7, then complete run
        do_load(32'd50, 32'd7);
        do_steps(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_rem", rem_out, 32'd0);
        check("t6_rst_quo", quo_out, 32'd0);
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        check("t6_rst_valid2", 32'(valid), 32'd0);

        do_load(32'd50, 32'd7);
        steps = 0;
        while (!is_less && steps < 40) begin
            do_steps(1);
            steps++;
        end
        check("t6_steps", 32'(steps), 32'd7);
        do_capture("t6", 32'd1, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
